// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle 16-bit MIPS-style core:
// opcodes, ALU control codes and the control FSM states.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_ADDI = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_e;

endpackage

// File: rtl/cpu_alu.sv
// Shared combinational ALU of the multi-cycle core.
// Used for arithmetic, address generation and branch compare.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        ctrl_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o,
  output logic              zero_o
);

  logic lt;

  assign lt = $signed(a_i) < $signed(b_i);

  always_comb begin
    y_o = '0;
    unique case (ctrl_i)
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_SLT: y_o = {{(DATA_W-1){1'b0}}, lt};
      ALU_NOR: y_o = ~(a_i | b_i);
      default: y_o = '0;
    endcase
  end

  assign zero_o = (y_o == '0);

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle 16-bit MIPS-style core: FSM, register file,
// internal instruction memory and data-memory req/ack handshake.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter  int DATA_W     = 16,
  parameter  int IMEM_DEPTH = 1024,
  parameter  int DMEM_AW    = 10,
  localparam int IA_W       = $clog2(IMEM_DEPTH),
  localparam int PC_W       = IA_W + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               imem_we,
  input  logic [IA_W-1:0]    imem_waddr,
  input  logic [15:0]        imem_wdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic [PC_W-1:0]    pc,
  output logic [15:0]        ir,
  output logic [DATA_W-1:0]  wd,
  output logic               reg_we,
  output logic               retire,
  output logic               halted,
  output logic               illegal
);

  state_e state_q, state_d;

  logic [15:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] regs_q [4];

  logic [PC_W-1:0]   pc_q;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, imm_q;
  logic [DATA_W-1:0] alu_q, mdr_q;
  logic              ill_q;

  logic [3:0]        op;
  logic [1:0]        rs, rt, rd;
  logic [DATA_W-1:0] sext;
  logic [PC_W-1:0]   br_off;

  logic is_r, is_addi, is_lw, is_sw;
  logic is_beq, is_bne, is_halt, legal;
  logic exec_last, take_br;
  logic [3:0] alu_ctrl;

  logic [DATA_W-1:0] alu_b, alu_y;
  logic              alu_zero;
  logic [DATA_W-1:0] wb_data;
  logic [1:0]        wb_dst;

  assign op   = ir_q[15:12];
  assign rs   = ir_q[11:10];
  assign rt   = ir_q[9:8];
  assign rd   = ir_q[7:6];
  assign sext = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
  assign br_off = {{(PC_W-9){ir_q[7]}}, ir_q[7:0], 1'b0};

  always_comb begin
    is_r     = 1'b0;
    is_addi  = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_halt  = 1'b0;
    alu_ctrl = ALU_ADD;
    unique case (op)
      OP_ADD:  is_r = 1'b1;
      OP_SUB:  begin is_r = 1'b1; alu_ctrl = ALU_SUB; end
      OP_AND:  begin is_r = 1'b1; alu_ctrl = ALU_AND; end
      OP_OR:   begin is_r = 1'b1; alu_ctrl = ALU_OR;  end
      OP_NOR:  begin is_r = 1'b1; alu_ctrl = ALU_NOR; end
      OP_SLT:  begin is_r = 1'b1; alu_ctrl = ALU_SLT; end
      OP_ADDI: is_addi = 1'b1;
      OP_LW:   is_lw = 1'b1;
      OP_SW:   is_sw = 1'b1;
      OP_BEQ:  begin is_beq = 1'b1; alu_ctrl = ALU_SUB; end
      OP_BNE:  begin is_bne = 1'b1; alu_ctrl = ALU_SUB; end
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  assign legal = is_r | is_addi | is_lw | is_sw |
                 is_beq | is_bne | is_halt;

  // Branches, halt and undefined opcodes all finish in EXEC
  assign exec_last = ~(is_r | is_addi | is_lw | is_sw);
  assign take_br   = (is_beq & alu_zero) | (is_bne & ~alu_zero);

  assign alu_b = (is_r | is_beq | is_bne) ? b_q : imm_q;

  cpu_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .ctrl_i(alu_ctrl),
    .a_i   (a_q),
    .b_i   (alu_b),
    .y_o   (alu_y),
    .zero_o(alu_zero)
  );

  assign wb_data = is_lw ? mdr_q : alu_q;
  assign wb_dst  = (is_lw | is_addi) ? rt : rd;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: state_d = EXEC;
      EXEC: begin
        if (is_r | is_addi)      state_d = WB;
        else if (is_lw | is_sw)  state_d = MEM;
        else if (is_halt)        state_d = HALT;
        else                     state_d = FETCH;
      end
      MEM: begin
        if (dmem_ack) state_d = is_lw ? WB : FETCH;
      end
      WB:     state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    dmem_req   = (state_q == MEM);
    dmem_we    = dmem_req & is_sw;
    dmem_addr  = alu_q[DMEM_AW:1];
    dmem_wdata = b_q;
    reg_we     = (state_q == WB);
    wd         = reg_we ? wb_data : '0;
    halted     = (state_q == HALT);
    retire     = reg_we |
                 (dmem_req & dmem_ack & is_sw) |
                 ((state_q == EXEC) & exec_last);
    pc         = pc_q;
    ir         = ir_q;
    illegal    = ill_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= '0;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      ill_q <= 1'b0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      unique case (state_q)
        FETCH: ir_q <= imem[pc_q[PC_W-1:1]];
        DECODE: begin
          a_q   <= regs_q[rs];
          b_q   <= regs_q[rt];
          imm_q <= sext;
          pc_q  <= pc_q + PC_W'(2);
        end
        EXEC: begin
          alu_q <= alu_y;
          if (take_br) pc_q <= pc_q + br_off;
          if (!legal)  ill_q <= 1'b1;
        end
        MEM: begin
          if (dmem_ack && is_lw) mdr_q <= dmem_rdata;
        end
        WB: begin
          // r0 is never written, so it keeps its reset value of zero
          if (wb_dst != 2'd0) regs_q[wb_dst] <= wb_data;
        end
        default: ;
      endcase
    end
  end

  // Program load port, open only while the core is held in reset
  always_ff @(posedge clock) begin
    if (reset && imem_we) imem[imem_waddr] <= imem_wdata;
  end

endmodule

// File: doc/multicycle_cpu.md
Name: multicycle_cpu

Overview:
- Parametrised multi-cycle successor to the single-cycle 16-bit MIPS-style core.
- Each instruction runs through a FETCH/DECODE/EXEC/MEM/WB state machine and reuses one ALU.
- Data memory is external, accessed over a req/ack handshake; instruction memory is internal and loaded through a write port while reset is held.
- Adds HALT, an illegal-opcode flag and a per-instruction retire pulse.

Parameters:
- DATA_W, 16, datapath/register width (≥16); immediates sign-extend to DATA_W.
- IMEM_DEPTH, 1024, instruction words (power of 2); PC width PC_W = log2(IMEM_DEPTH)+1, byte addressed.
- DMEM_AW, 10, data word-address width on dmem_addr.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- imem_we  in  1  instruction write strobe; honoured only while reset=1.
- imem_waddr  in  log2(IMEM_DEPTH)  word address for load.
- imem_wdata  in  16  instruction word.
- dmem_req  out  1  data access request, held until ack.
- dmem_we  out  1  1=store, 0=load; valid with req.
- dmem_addr  out  DMEM_AW  word address = ALUOut[DMEM_AW:1].
- dmem_wdata  out  DATA_W  store data (rt value).
- dmem_rdata  in  DATA_W  load data, sampled in ack cycle.
- dmem_ack  in  1  completes the transaction at this posedge.
- pc  out  PC_W  current instruction byte address.
- ir  out  16  latched instruction.
- wd  out  DATA_W  register write data (debug).
- reg_we  out  1  register write this cycle.
- retire  out  1  one-cycle pulse as each instruction completes.
- halted  out  1  core stopped on HALT.
- illegal  out  1  sticky: undefined opcode seen.

Behaviour:
- Reset (sync): pc=0, ir=0, state=FETCH, regs r1..r3=0, all outputs 0; imem contents preserved. Reset mid-transaction: dmem_req=0 next cycle, access abandoned.
- Format: op[15:12], rs[11:10], rt[9:8], rd[7:6] (R-type), imm[7:0] (I-type). Four registers; r0 reads 0 and writes to it are dropped.
- Opcodes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 nor, 0101 slt (signed), 0111 addi, 1000 lw, 1001 sw, 1010 beq, 1011 bne, 1111 halt. All others: illegal=1, executed as NOP.
- FETCH: ir<=imem[pc>>1]. DECODE: latch A=R[rs], B=R[rt], sext(imm); pc<=pc+2. EXEC: ALUOut<=A op (B|sext); branch: if (beq&&A==B)||(bne&&A!=B) then pc<=pc+2 (already incremented) + (sext(imm)<<1).
- MEM: dmem_req=1 until ack sampled high; ack in the first MEM cycle is allowed (zero wait). ack while req=0 is ignored. lw latches dmem_rdata.
- WB: reg_we=1 for one cycle; R-type writes rd, addi/lw write rt. wd shows the data.
- Cycles: R-type/addi 4, lw 5+waits, sw 4+waits, beq/bne/NOP 3. retire pulses in the last cycle.
- HALT: retire pulses, then state HALT with halted=1; no further fetches until reset.
- Arithmetic wraps modulo 2^DATA_W; no overflow trap. pc wraps modulo 2*IMEM_DEPTH.

Decomposition:
- Package cpu_pkg: opcode constants, ALU control codes (0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1100 nor), state enum {FETCH, DECODE, EXEC, MEM, WB, HALT}.
- Sub-module cpu_alu: combinational, parametrised by DATA_W, with a zero flag. The top holds the FSM, regfile, imem and handshake.

Test Plan:
- Load the swap/abs program (lw r1,0; lw r2,2; slt r3,r1,r2; beq r3,r0,+2; sw r1,2; sw r2,0; lw r1,0; lw r2,2; nor r2,r2,r2; addi r2,r2,1; add r3,r1,r2) with mem[0]=5, mem[1]=7, zero-wait ack -> final wd=2 (r3). With bne instead of beq -> r3=-2 (0xFFFE).
- Same program with ack delayed 3 cycles on every access -> identical register results; each lw/sw takes exactly 3 extra cycles; req stays high throughout.
- addi r1,r0,0x7F then add r1,r1,r1 ×9 with DATA_W=16 -> wraps modulo 2^16 to 0xFE00 (0x7F·512 mod 65536); no trap.
- Opcode 0110 then halt -> illegal=1, NOP taken in 3 cycles, halted=1, pc frozen, retire silent afterwards.
- Assert reset during MEM wait (req=1) -> req=0 next cycle, pc=0, registers cleared, imem kept; re-run gives the same result.
- add r0,r1,r1 with r1=3 -> r0 still reads 0; reg_we pulses with wd=6.
